recepcion_uart: RTL and testbench
=================================

// Module: recepcion_uart
//
// PURPOSE
//   Serial UART receiver for the Bluetooth peripheral. It is the downstream
//   partner of the transmitter stage: it takes the BT module's TX line,
//   recovers 8N1 frames and presents each byte with a one-cycle done strobe
//   to the peripheral register/command logic. Baud rate is fixed by a
//   clock-per-bit count. Default is 50 MHz / 9600 baud.
//
// PARAMETERS
//   CLKS_PER_BIT  5208  clk_in cycles per serial bit (must be >= 8)
//   DATA_BITS     8     data bits per frame, LSB first (1..8)
//
// PORTS
//   clk_in     in   1          system clock, all logic on rising edge
//   reset      in   1          asynchronous, active-high reset
//   rx         in   1          serial line from BT module, idle high, asynchronous
//   dout       out  DATA_BITS  last correctly framed byte, held until the next good frame
//   done       out  1          1-cycle pulse: dout has just been updated
//   frame_err  out  1          1-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  1          high whenever state != IDLE
//
// BEHAVIOUR
//   - Reset values (async, take effect immediately):
//       dout = 0, done = 0, frame_err = 0, busy = 0, state = IDLE,
//       counters = 0, both synchroniser flops = 1.
//   - rx passes through a 2-flop synchroniser (rx_s). Only rx_s is used.
//   - HALF = CLKS_PER_BIT/2 (integer divide).
//   - Bit counter: $clog2(CLKS_PER_BIT) bits wide. Bit index: 4 bits.
//     No counter may wrap past its terminal value.
//   - FSM states:
//       IDLE:  counters cleared.
//              rx_s == 0 -> START.
//       START: count 0..HALF-1; sample rx_s at count == HALF-1.
//              rx_s == 1 -> glitch: IDLE, no strobe.
//              rx_s == 0 -> clear counter, bit index = 0, go to DATA.
//       DATA:  count 0..CLKS_PER_BIT-1; at the terminal count shift rx_s
//              into shift-reg[bit index] and increment the index.
//              After bit DATA_BITS-1 -> STOP.
//       STOP:  count 0..CLKS_PER_BIT-1; sample rx_s at the terminal count.
//              rx_s == 1 -> dout <= shift-reg, done = 1 for exactly 1 cycle.
//              rx_s == 0 -> frame_err = 1 for exactly 1 cycle, dout unchanged.
//              Either way -> IDLE in the same cycle as the strobe.
//   - done and frame_err are registered, mutually exclusive and never held.
//     Each frame produces at most one of them.
//   - Latency: done asserts exactly
//       2 + 1 + HALF + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT cycles
//     after the rx falling edge.
//   - Back-to-back frames: IDLE is reached at mid-stop-bit, so a start bit
//     that follows a single stop bit is caught. The stop-bit half is idle
//     high and causes no false start.
//   - Line held low (break): START confirms, DATA reads zeros, STOP gives
//     frame_err. The FSM then stays in IDLE->START cycling. Each pass
//     yields frame_err, never done, until rx returns high.
//   - Reset mid-frame: the partial frame is dropped with no strobe. After
//     release, reception restarts on the next falling edge of rx_s.
//   - busy is combinational from state only.
//
// TESTING  (bench uses CLKS_PER_BIT=16, DATA_BITS=8)
//   1. Send 8N1 0xA5 -> one done pulse at 2+1+8+128+16=155 clk after the
//      start edge; dout=0xA5; frame_err stays 0; busy falls with done.
//   2. Pulse rx low for 4 clk, then high -> no done/frame_err; busy high
//      for about 9 clk, then 0; dout unchanged.
//   3. Send 0x3C with stop bit driven low -> one frame_err pulse, no done;
//      dout still holds 0xA5 from test 1.
//   4. Send 0x00 then 0xFF back to back with one stop bit between ->
//      two done pulses 160 clk apart; dout=0x00, then dout=0xFF.
//   5. Assert reset mid DATA of 0x5A (after bit 3) -> dout=0, busy=0
//      at once, no strobe. Release and send 0x81 -> done with dout=0x81.
//   6. Hold rx low for 400 clk, then high -> only frame_err pulses, no
//      done; next frame 0x42 is received correctly.

Source files
------------

// File: rtl/recepcion_uart.sv
// recepcion_uart: 8N1-style serial receiver for the Bluetooth peripheral.
// The rx line is synchronised and then timed with a clock-per-bit counter.
// The start bit is confirmed at its midpoint, and every later bit is sampled
// one full bit period after the previous sample. Each frame ends with either
// a one-cycle done strobe (new byte on dout) or a one-cycle frame_err strobe.

module recepcion_uart #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic                 rxMeta_q;
    logic                 rxSync_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [3:0]           index_q, index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 frameErr_q, frameErr_d;

    logic countHalf;
    logic countEnd;
    logic lastBit;

    assign countHalf = (count_q == HALF_LAST);
    assign countEnd  = (count_q == BIT_LAST);
    assign lastBit   = (index_q == IDX_LAST);

    // Two-flop synchroniser; both stages reset to the idle-high line level
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // State register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame sequencing driven by the bit-timing counter
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (countHalf) begin
                    state_d = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (countEnd && lastBit) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (countEnd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath logic: counters, shift register and the result strobes
    always_comb begin
        count_d    = count_q;
        index_d    = index_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        frameErr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                index_d = '0;
            end
            START: begin
                if (countHalf) begin
                    count_d = '0;
                    index_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            DATA: begin
                if (countEnd) begin
                    count_d = '0;
                    for (int b = 0; b < DATA_BITS; b++) begin
                        if (index_q == 4'(b)) begin
                            shift_d[b] = rxSync_q;
                        end
                    end
                    if (!lastBit) begin
                        index_d = index_q + 4'd1;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            STOP: begin
                if (countEnd) begin
                    count_d = '0;
                    if (rxSync_q) begin
                        dout_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                count_d = '0;
                index_d = '0;
            end
        endcase
    end

    // Datapath registers; the strobes are registered so they last one cycle
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            index_q    <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            index_q    <= index_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign frame_err = frameErr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_recepcion_uart.sv
// Self-checking bench for recepcion_uart (CLKS_PER_BIT=16, DATA_BITS=8).
// The reference model keeps a history of the rx level at every clock edge.
// From that history it derives, with plain arithmetic on edge numbers, when
// each strobe must appear and what it must carry.

module tb_recepcion_uart;

    localparam int CPB     = 16;
    localparam int NB      = 8;
    localparam int HALF    = CPB / 2;
    localparam int LATENCY = 2 + 1 + HALF + NB * CPB + CPB;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic [7:0] dout;
    logic       done;
    logic       frame_err;
    logic       busy;

    recepcion_uart #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (NB)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .rx       (rx),
        .dout     (dout),
        .done     (done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int isErr;
        int data;
    } strobeRec_t;

    strobeRec_t obsQ[$];
    strobeRec_t expQ[$];

    int edgeNum  = 0;
    int segStart = 1;
    int modelPos = 1;
    int expDout  = 0;
    bit rxHist [0:65535];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Edge bookkeeping: record the rx level latched at each edge; reset restarts the model
    always @(posedge clk_in) begin
        edgeNum = edgeNum + 1;
        if (edgeNum < 65536) begin
            rxHist[edgeNum] = rx;
        end
        if (reset) begin
            segStart = edgeNum + 1;
            modelPos = edgeNum + 1;
            expDout  = 0;
        end
    end

    // Strobe monitor: log every done/frame_err pulse with its edge number
    always @(negedge clk_in) begin
        strobeRec_t rec;
        if (!reset && (done || frame_err)) begin
            rec.cyc   = edgeNum;
            rec.isErr = frame_err ? 1 : 0;
            rec.data  = int'(dout);
            obsQ.push_back(rec);
            checkOutput("strobeExclusive", int'(done && frame_err), 0);
            checkOutput("busyAtStrobe", int'(busy), 0);
        end
    end

    // Synchronised line level seen by the receiver at edge n
    function automatic int rxsAt(input int n);
        int m;
        m = n - 2;
        if (m < segStart) begin
            return 1;
        end
        return int'(rxHist[m]);
    endfunction

    // Walk the line history: falling level -> mid-start check -> bit-period samples
    task automatic runModel(input int limit);
        int s;
        int p;
        int v;
        strobeRec_t rec;
        while (modelPos <= limit) begin
            if (rxsAt(modelPos) != 0) begin
                modelPos++;
                continue;
            end
            s = modelPos + HALF;
            if (s > limit) break;
            if (rxsAt(s) == 1) begin
                modelPos = s + 1;
                continue;
            end
            p = s + (NB + 1) * CPB;
            if (p > limit) break;
            v = 0;
            for (int i = 0; i < NB; i++) begin
                v = v | (rxsAt(s + (i + 1) * CPB) << i);
            end
            rec.cyc = p;
            if (rxsAt(p) == 1) begin
                expDout   = v;
                rec.isErr = 0;
            end else begin
                rec.isErr = 1;
            end
            rec.data = expDout;
            expQ.push_back(rec);
            modelPos = p + 1;
        end
    endtask

    task automatic checkEvents(input string tag);
        strobeRec_t e;
        strobeRec_t o;
        runModel(edgeNum);
        checkOutput({tag, ".strobeCount"}, obsQ.size(), expQ.size());
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checkOutput({tag, ".strobeEdge"}, o.cyc, e.cyc);
            checkOutput({tag, ".strobeKind"}, o.isErr, e.isErr);
            checkOutput({tag, ".strobeDout"}, o.data, e.data);
        end
        obsQ.delete();
        expQ.delete();
        checkOutput({tag, ".dout"}, int'(dout), expDout);
        checkOutput({tag, ".busyIdle"}, int'(busy), 0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopLevel);
        rx = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < NB; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk_in);
        end
        rx = stopLevel;
        repeat (CPB) @(negedge clk_in);
        rx = 1'b1;
    endtask

    // Hard stop in case anything stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int k;
        int nDone;
        int kind;
        int gap;
        logic [7:0] data;

        // Reset state
        repeat (3) @(negedge clk_in);
        checkOutput("reset.dout", int'(dout), 0);
        checkOutput("reset.done", int'(done), 0);
        checkOutput("reset.frameErr", int'(frame_err), 0);
        checkOutput("reset.busy", int'(busy), 0);
        reset = 1'b0;
        idle(20);

        // Test 1: clean 0xA5, latency measured from the falling edge
        $display("[TB] test 1: frame 0xA5");
        t0 = edgeNum;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                repeat (60) @(negedge clk_in);
                checkOutput("t1.busyMid", int'(busy), 1);
            end
        join
        idle(40);
        if (obsQ.size() > 0) checkOutput("t1.latency", obsQ[0].cyc - t0, LATENCY);
        else                 checkOutput("t1.latency", -1, LATENCY);
        checkEvents("t1");
        checkOutput("t1.doutA5", int'(dout), 8'hA5);

        // Test 2: 4-cycle glitch must abort in START
        $display("[TB] test 2: start-bit glitch");
        rx = 1'b0;
        repeat (4) @(negedge clk_in);
        rx = 1'b1;
        repeat (2) @(negedge clk_in);
        checkOutput("t2.busyDuringGlitch", int'(busy), 1);
        repeat (14) @(negedge clk_in);
        checkOutput("t2.busyAfterGlitch", int'(busy), 0);
        idle(20);
        checkEvents("t2");

        // Test 3: bad stop bit
        $display("[TB] test 3: frame 0x3C with low stop bit");
        applyStimulus(8'h3C, 1'b0);
        idle(40);
        checkEvents("t3");
        checkOutput("t3.doutKept", int'(dout), 8'hA5);

        // Test 4: back-to-back 0x00, 0xFF
        $display("[TB] test 4: back-to-back frames");
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        idle(40);
        if (obsQ.size() >= 2) checkOutput("t4.spacing", obsQ[1].cyc - obsQ[0].cyc, 10 * CPB);
        else                  checkOutput("t4.spacing", -1, 10 * CPB);
        checkEvents("t4");

        // Test 5: reset in the middle of DATA
        $display("[TB] test 5: reset mid-frame");
        data = 8'h5A;
        rx = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk_in);
        end
        rx = data[4];
        repeat (HALF) @(negedge clk_in);
        checkOutput("t5.busyBeforeReset", int'(busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("t5.doutAtReset", int'(dout), 0);
        checkOutput("t5.busyAtReset", int'(busy), 0);
        checkOutput("t5.doneAtReset", int'(done), 0);
        rx = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        idle(20);
        applyStimulus(8'h81, 1'b1);
        idle(40);
        checkEvents("t5");
        checkOutput("t5.dout81", int'(dout), 8'h81);

        // Test 6: line held low, released right after a frame_err pulse
        $display("[TB] test 6: break condition");
        rx = 1'b0;
        repeat (400) @(negedge clk_in);
        k = 0;
        while (!frame_err && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        rx = 1'b1;
        checkOutput("t6.frameErrSeen", int'(frame_err), 1);
        idle(40);
        nDone = 0;
        foreach (obsQ[i]) if (obsQ[i].isErr == 0) nDone++;
        checkOutput("t6.noDoneInBreak", nDone, 0);
        checkOutput("t6.errPulses", obsQ.size(), 3);
        checkEvents("t6break");
        applyStimulus(8'h42, 1'b1);
        idle(40);
        checkEvents("t6");
        checkOutput("t6.dout42", int'(dout), 8'h42);

        // Randomised frames, glitches, bad stops and gaps (including none)
        $display("[TB] random traffic");
        for (int r = 0; r < 14; r++) begin
            kind = $urandom_range(0, 9);
            data = 8'($urandom_range(0, 255));
            gap  = $urandom_range(0, 24);
            if (kind == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk_in);
                rx = 1'b1;
            end else begin
                applyStimulus(data, (kind != 1));
            end
            idle(gap);
        end
        idle(200);
        checkEvents("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
